// File: rtl/pcm_to_float_pkg.sv
// Shared constants and FSM encoding for the PCM-to-float converter and the downstream float stage.
// Float format: {sign, 7-bit exponent biased by 63, 16-bit mantissa with hidden leading one}.
package pcm_to_float_pkg;

    localparam int PCM_W    = 24;
    localparam int FLT_W    = 24;
    localparam int EXP_W    = 7;
    localparam int MAN_W    = 16;
    localparam int EXP_BIAS = 63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_PACK = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    function automatic logic [FLT_W-1:0] pack_float(
        input logic             sign,
        input logic [EXP_W-1:0] exp,
        input logic [MAN_W-1:0] man
    );
        return {sign, exp, man};
    endfunction

endpackage

// File: rtl/pcm_round.sv
// Mantissa extraction from a normalised magnitude; round-to-nearest-even when PCM_TO_FLOAT_ROUND_EN is defined, else truncate.
// Latency: combinational. Backpressure: none (pure function of i_mag).
// A carry-out means the rounded mantissa wrapped to zero and the exponent must be bumped by one.
module pcm_round
    import pcm_to_float_pkg::*;
(
    input  logic [PCM_W-2:0] i_mag,
    output logic [MAN_W-1:0] o_mantissa,
    output logic             o_carry
);

`ifdef PCM_TO_FLOAT_ROUND_EN
    logic             w_inc;
    logic [MAN_W:0]   w_sum;

    // guard = bit 6, sticky = OR of bits 5:0, ties resolved towards an even mantissa
    assign w_inc      = i_mag[6] & ((|i_mag[5:0]) | i_mag[7]);
    assign w_sum      = {1'b0, i_mag[22:7]} + {{MAN_W{1'b0}}, w_inc};
    assign o_mantissa = w_sum[MAN_W-1:0];
    assign o_carry    = w_sum[MAN_W];
`else
    logic w_unused_low;

    assign w_unused_low = ^i_mag[6:0];
    assign o_mantissa   = i_mag[22:7];
    assign o_carry      = 1'b0;
`endif

endmodule

// File: rtl/pcm_to_float.sv
// Converts one signed Q1.23 PCM sample into the 24-bit float format, one sample in flight.
// Latency: k+3 edges from accept (k = normalising shifts, 0..23). Rounding via PCM_TO_FLOAT_ROUND_EN (see pcm_round).
// Backpressure: in_ready only in IDLE; result held in OUT until out_ready.
module pcm_to_float
    import pcm_to_float_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PCM_W-1:0] pcm_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [FLT_W-1:0] float_out,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           r_state;
    state_t           w_next;
    logic             r_sign;
    logic             r_zero;
    logic [PCM_W-1:0] r_mag;
    logic [EXP_W-1:0] r_exp;
    logic [FLT_W-1:0] r_float;

    logic [PCM_W:0]   w_ext;
    logic [PCM_W:0]   w_abs;
    logic             w_mag_zero;
    logic [MAN_W-1:0] w_man;
    logic             w_carry;

    // 25-bit negate so -2^23 yields 2^23; its low 24 bits still carry bit 23 set
    assign w_ext      = {pcm_in[PCM_W-1], pcm_in};
    assign w_abs      = pcm_in[PCM_W-1] ? (~w_ext + {{PCM_W{1'b0}}, 1'b1}) : w_ext;
    assign w_mag_zero = (r_mag == '0);

    pcm_round u_round (
        .i_mag      (r_mag[PCM_W-2:0]),
        .o_mantissa (w_man),
        .o_carry    (w_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)            w_next = ST_NORM;
            ST_NORM: if (w_mag_zero || r_mag[PCM_W-1]) w_next = ST_PACK;
            ST_PACK:                          w_next = ST_OUT;
            ST_OUT:  if (out_ready)           w_next = ST_IDLE;
            default:                          w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_OUT);
        float_out = r_float;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sign  <= 1'b0;
            r_zero  <= 1'b0;
            r_mag   <= '0;
            r_exp   <= '0;
            r_float <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign <= pcm_in[PCM_W-1];
                        r_mag  <= w_abs[PCM_W-1:0];
                        r_exp  <= EXP_BIAS[EXP_W-1:0];
                        r_zero <= 1'b0;
                    end
                end
                ST_NORM: begin
                    if (w_mag_zero) begin
                        r_zero <= 1'b1;
                    end else if (!r_mag[PCM_W-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 1'b1;
                    end
                end
                ST_PACK: begin
                    // zero has no hidden one, so it is emitted as all-zero with sign cleared
                    if (r_zero) begin
                        r_float <= '0;
                    end else begin
                        r_float <= pack_float(r_sign, r_exp + {{(EXP_W-1){1'b0}}, w_carry}, w_man);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_to_float.sv
// Directed-vector bench for pcm_to_float: conversion values, latency, back-pressure and mid-operation reset.
module tb_pcm_to_float;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pcm_in;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] float_out;
    logic        out_valid;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;

    pcm_to_float dut (
        .clk       (clk),
        .rst       (rst),
        .pcm_in    (pcm_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .float_out (float_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // accept one sample, count edges to out_valid (accept edge = 1), check, then drain
    task automatic convert(input string tag, input logic [23:0] pcm, input logic [23:0] expf, input int k);
        int edges;
        @(negedge clk);
        expect_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        pcm_in   = pcm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges    = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        expect_eq({tag, "_latency"}, edges, k + 3);
        expect_eq({tag, "_value"}, {8'd0, float_out}, {8'd0, expf});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        expect_eq({tag, "_drained"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int edges;
        int stray;
        rst       = 1'b0;
        pcm_in    = 24'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        expect_eq("rst_float_out", {8'd0, float_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        expect_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        convert("half",      24'h400000, 24'h3E0000, 1);
        convert("minus_one", 24'h800000, 24'hBF0000, 0);
        convert("zero",      24'h000000, 24'h000000, 0);
        convert("lsb",       24'h000001, 24'h280000, 23);
        convert("neg_half",  24'hC00000, 24'hBE0000, 1);
        convert("three_q",   24'h600000, 24'h3E8000, 1);
        convert("tie_even",  24'h400020, 24'h3E0000, 1);
`ifdef PCM_TO_FLOAT_ROUND_EN
        convert("max_pos",   24'h7FFFFF, 24'h3F0000, 1);
        convert("tie_odd",   24'h400060, 24'h3E0002, 1);
`else
        convert("max_pos",   24'h7FFFFF, 24'h3EFFFF, 1);
        convert("tie_odd",   24'h400060, 24'h3E0001, 1);
`endif

        // back-pressure: hold the result for 10 cycles while a second sample is offered
        @(negedge clk);
        pcm_in   = 24'h400000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges    = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        expect_eq("bp_latency", edges, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pcm_in   = 24'h000001;
            in_valid = 1'b1;
            @(posedge clk); #1;
            expect_eq("bp_hold_value", {8'd0, float_out}, 32'h003E0000);
            expect_eq("bp_hold_flags", {30'd0, out_valid, in_ready}, 32'd2);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        expect_eq("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
        stray = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        out_ready = 1'b0;
        expect_eq("bp_single_xfer", stray, 0);

        // reset while normalising the smallest sample
        @(negedge clk);
        pcm_in   = 24'h000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_eq("mid_busy", {31'd0, in_ready}, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        expect_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        expect_eq("mid_rst_float", {8'd0, float_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        expect_eq("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        stray     = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        out_ready = 1'b0;
        expect_eq("mid_no_stale", stray, 0);
        convert("after_rst", 24'h400000, 24'h3E0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
